uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
// - Frame controller for the UART receiver. Sequences the majority-vote data sampler.
// - Generates dat_samp_en and the per-bit edge_cnt. Consumes sampled_bit.
// - Checks start, parity and stop bits. Deserializes data LSB-first into P_DATA.
// - Sits between the RX pin sampler and the RX-side sync FIFO; single clock domain (RX clock).
// PARAMETERS
// - DATA_WIDTH  8  data bits per frame (5..8 legal)
// PORTS
// - clk          in   1           RX oversampling clock
// - rst          in   1           synchronous reset, active-high
// - RX_IN        in   1           serial line, idle high (already synchronised)
// - Prescale     in   6           oversampling ratio; legal 8, 16, 32
// - PAR_EN       in   1           1 = parity bit present after data
// - PAR_TYP      in   1           0 = even, 1 = odd
// - sampled_bit  in   1           registered majority-vote result from the sampler
// - dat_samp_en  out  1           enables the sampler; low clears it to idle-high
// - edge_cnt     out  5           oversample index within current bit, 0..Prescale-1
// - P_DATA       out  DATA_WIDTH  last good frame data
// - data_valid   out  1           one-cycle strobe: P_DATA updated
// - par_err      out  1           parity mismatch on last frame, sticky until next start
// - stop_err     out  1           stop bit sampled low on last frame, sticky until next start
// BEHAVIOUR
// - Reset (rst=1 at posedge): state=IDLE, edge_cnt=0, bit_cnt=0, dat_samp_en=0.
//   - Reset also clears P_DATA=0, data_valid=0, par_err=0, stop_err=0.
//   - Reset mid-frame aborts the frame; no strobe is issued.
// - Config capture: Prescale, PAR_EN and PAR_TYP are latched on the IDLE->START transition.
//   - Input changes mid-frame have no effect.
// - States: IDLE, START, DATA, PARITY, STOP.
//   - dat_samp_en=1 in every state except IDLE.
// - edge_cnt rules:
//   - Increments every cycle outside IDLE.
//   - Wraps to 0 at Prescale_lat-1; that cycle is the bit end.
//   - Held at 0 in IDLE.
// - sampled_bit is evaluated only at bit end (edge_cnt==Prescale_lat-1).
// - Transitions:
//   - IDLE: RX_IN==0 -> START; clear par_err/stop_err; edge_cnt=0 next cycle.
//     - If latched Prescale <8 or not a power of 2, remain IDLE.
//   - START: at bit end, sampled_bit==1 -> IDLE (glitch, no flags); else -> DATA, bit_cnt=0.
//   - DATA: at bit end, shift sampled_bit into shift_reg[bit_cnt]; bit_cnt++.
//     - Last bit (bit_cnt==DATA_WIDTH-1) -> PARITY if PAR_EN_lat, else STOP.
//   - PARITY: at bit end, expected = ^shift_reg ^ PAR_TYP_lat.
//     - par_err <= (sampled_bit != expected). Always -> STOP.
//   - STOP: at bit end, stop_err <= ~sampled_bit.
//     - If no par_err and sampled_bit==1: P_DATA<=shift_reg, data_valid=1 next cycle.
//     - Always -> IDLE.
// - Latency: start edge seen at posedge k -> data_valid high at k + N*P + 1.
//   - N = 1 + DATA_WIDTH + PAR_EN + 1; P = Prescale_lat.
// - data_valid: high exactly 1 cycle; never asserted on an errored frame.
//   - P_DATA is held otherwise.
// - Back-to-back frames: IDLE re-detects RX_IN==0 on the cycle after STOP.
//   - Next frame has 1-cycle phase slip; tolerated.
// - Line held low after STOP: treated as a new start bit; start check then passes or fails normally.
// CONFIGURATION
// - UART_RX_BREAK_DET_EN defined:
//   - Adds output brk_det (1 bit, reset 0).
//   - Pulses 1 cycle when a frame has all data bits 0 and stop bit 0 (framing-error break).
//   - Parity is ignored for this detection.
//   - stop_err is still set; data_valid is not asserted.
// - UART_RX_BREAK_DET_EN undefined: port brk_det absent; a break is reported only as stop_err.
// TESTING
// - Prescale=8, PAR_EN=0, frame 0xA5 -> data_valid 1 cycle at k+81, P_DATA=0xA5, par_err=stop_err=0.
// - Prescale=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity 0 -> data_valid at k+177, P_DATA=0x3C.
//   - Same frame with parity 1 -> par_err=1, no data_valid.
// - Prescale=8, RX_IN low for 3 cycles then high -> START fails, returns IDLE, no flags, dat_samp_en=0.
// - Prescale=32, 0x00 with stop bit low -> stop_err=1, no data_valid.
//   - With UART_RX_BREAK_DET_EN: brk_det pulse.
// - rst=1 during DATA bit 4 -> next cycle IDLE, edge_cnt=0, all outputs 0.
//   - A subsequent 0x5A frame decodes correctly.
// - Two back-to-back frames 0x11, 0x22 at Prescale=8 -> two data_valid strobes, 81 cycles apart.
//   - Values 0x11 then 0x22.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl - frame controller for the UART receiver.
//
// Sequences the external majority-vote data sampler through one serial frame:
// start bit, DATA_WIDTH data bits (LSB first), an optional parity bit and a
// stop bit. Every bit is judged once, on its last oversample, using the
// sampler's registered result. Good frames are presented on P_DATA with a
// one-cycle data_valid strobe for the RX-side sync FIFO.
//
// Optional feature macro: UART_RX_BREAK_DET_EN
//   defined   -> adds output brk_det, a one-cycle pulse on a break frame
//                (all data bits 0 and stop bit 0, parity ignored)
//   undefined -> no brk_det port; a break shows up only as stop_err
//
// Ports
//   clk          in   RX oversampling clock
//   rst          in   synchronous reset, active-high
//   RX_IN        in   serial line, idle high, already synchronised
//   Prescale     in   oversampling ratio (8, 16 or 32), latched at frame start
//   PAR_EN       in   1 = parity bit follows the data bits, latched at frame start
//   PAR_TYP      in   0 = even, 1 = odd parity, latched at frame start
//   sampled_bit  in   registered majority-vote result from the sampler
//   dat_samp_en  out  sampler enable; low returns the sampler to idle-high
//   edge_cnt     out  oversample index within the current bit
//   P_DATA       out  data of the last good frame
//   data_valid   out  one-cycle strobe, P_DATA just updated
//   par_err      out  parity mismatch on last frame, sticky until next start
//   stop_err     out  stop bit sampled low on last frame, sticky until next start
//   brk_det      out  (UART_RX_BREAK_DET_EN only) break-frame pulse

module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  dat_samp_en,
  output logic [4:0]            edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                  brk_det
`endif
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rxState_e;

  rxState_e              state_q;
  logic [4:0]            edgeCnt_q;
  logic [4:0]            edgeCnt_d;
  logic [BCW-1:0]        bitCnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] pData_q;
  logic [5:0]            prescale_q;
  logic                  parEn_q;
  logic                  parTyp_q;
  logic                  datSampEn_q;
  logic                  dataValid_q;
  logic                  parErr_q;
  logic                  stopErr_q;
  logic                  bitEnd;
  logic                  lastBit;
  logic                  prescaleOk;
  logic                  expParity;
`ifdef UART_RX_BREAK_DET_EN
  logic                  brkDet_q;
`endif

  // Bit timing and per-bit decisions derived from the current state.
  // bitEnd marks the last oversample of a bit, the only cycle on which the
  // sampler result is trusted; the counter wraps to 0 on that same cycle.
  // Only the three legal ratios may start a frame, so edge_cnt always fits.
  always_comb begin
    bitEnd     = (edgeCnt_q == 5'(prescale_q - 6'd1));
    edgeCnt_d  = bitEnd ? 5'd0 : edgeCnt_q + 5'd1;
    lastBit    = (bitCnt_q == BCW'(DATA_WIDTH - 1));
    prescaleOk = (Prescale == 6'd8) || (Prescale == 6'd16) || (Prescale == 6'd32);
    expParity  = (^shift_q) ^ parTyp_q;
  end

  // Frame FSM with all outputs registered. Configuration is captured on the
  // IDLE->START step so a frame is decoded with one consistent setting even
  // if software reprograms the inputs mid-frame. The sticky error flags are
  // cleared only when a new start is accepted, so they describe the last
  // frame until the next one begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      edgeCnt_q   <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      pData_q     <= '0;
      prescale_q  <= 6'd8;
      parEn_q     <= 1'b0;
      parTyp_q    <= 1'b0;
      datSampEn_q <= 1'b0;
      dataValid_q <= 1'b0;
      parErr_q    <= 1'b0;
      stopErr_q   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brkDet_q    <= 1'b0;
`endif
    end else begin
      dataValid_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brkDet_q    <= 1'b0;
`endif
      edgeCnt_q   <= (state_q == IDLE) ? 5'd0 : edgeCnt_d;

      case (state_q)
        IDLE: begin
          if (!RX_IN && prescaleOk) begin
            state_q     <= START;
            datSampEn_q <= 1'b1;
            prescale_q  <= Prescale;
            parEn_q     <= PAR_EN;
            parTyp_q    <= PAR_TYP;
            parErr_q    <= 1'b0;
            stopErr_q   <= 1'b0;
          end
        end

        // A start bit that reads back high was a line glitch: drop it quietly.
        START: begin
          if (bitEnd) begin
            if (sampled_bit) begin
              state_q     <= IDLE;
              datSampEn_q <= 1'b0;
            end else begin
              state_q  <= DATA;
              bitCnt_q <= '0;
            end
          end
        end

        DATA: begin
          if (bitEnd) begin
            shift_q[bitCnt_q] <= sampled_bit;
            bitCnt_q          <= bitCnt_q + 1'b1;
            if (lastBit) begin
              state_q <= parEn_q ? PARITY : STOP;
            end
          end
        end

        PARITY: begin
          if (bitEnd) begin
            parErr_q <= (sampled_bit != expParity);
            state_q  <= STOP;
          end
        end

        // The frame is published only when both parity and stop bit are good.
        STOP: begin
          if (bitEnd) begin
            stopErr_q   <= ~sampled_bit;
            state_q     <= IDLE;
            datSampEn_q <= 1'b0;
            if (!parErr_q && sampled_bit) begin
              pData_q     <= shift_q;
              dataValid_q <= 1'b1;
            end
`ifdef UART_RX_BREAK_DET_EN
            brkDet_q <= (shift_q == '0) && !sampled_bit;
`endif
          end
        end

        default: begin
          state_q     <= IDLE;
          datSampEn_q <= 1'b0;
        end
      endcase
    end
  end

  assign dat_samp_en = datSampEn_q;
  assign edge_cnt    = edgeCnt_q;
  assign P_DATA      = pData_q;
  assign data_valid  = dataValid_q;
  assign par_err     = parErr_q;
  assign stop_err    = stopErr_q;
`ifdef UART_RX_BREAK_DET_EN
  assign brk_det     = brkDet_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl - directed bench for uart_rx_ctrl.
//
// The bench plays the role of both the line and the sampler: for each bit it
// drives RX_IN and sampled_bit to the bit value for a whole bit period, so the
// controller sees the intended value on every bit-end sample. Expected data,
// parity bits and strobe latencies are hand-computed constants.
//
// Cycle bookkeeping: 'cycle' counts posedges. A start is "seen at posedge k"
// when the DUT in IDLE samples RX_IN low at posedge k. A data_valid strobe is
// stamped with the index of the first posedge at which it is sampled high by a
// downstream register, so a good frame must stamp k + N*P + 1.

module tb_uart_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       sampled_bit;
  logic       dat_samp_en;
  logic [4:0] edge_cnt;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stop_err;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk_det;
`endif

  int         checks;
  int         fails;
  int         cycle;
  int         dvCount;
  int         brkCount;
  int         startCyc;
  int         dvCyc[$];
  logic [7:0] dvDat[$];

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .sampled_bit (sampled_bit),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stop_err    (stop_err)
`ifdef UART_RX_BREAK_DET_EN
    ,
    .brk_det     (brk_det)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Posedge counter used to time-stamp starts and strobes.
  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Strobe monitor, sampling on the falling edge away from the active edge.
  // Counting high negedges also catches a strobe that lasts too long.
  initial begin
    dvCount  = 0;
    brkCount = 0;
  end
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dvCount = dvCount + 1;
      dvCyc.push_back(cycle + 1);
      dvDat.push_back(P_DATA);
    end
`ifdef UART_RX_BREAK_DET_EN
    if (brk_det === 1'b1) brkCount = brkCount + 1;
`endif
  end

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      fails = fails + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Builds a serial frame: start 0, data LSB first, optional parity, stop.
  task automatic makeFrame(input logic [7:0] data, input logic withPar,
                           input logic parBit, input logic stopBit,
                           output logic [15:0] seq, output int nb);
    seq    = '0;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[1+i] = data[i];
    nb = 9;
    if (withPar) begin
      seq[nb] = parBit;
      nb      = nb + 1;
    end
    seq[nb] = stopBit;
    nb      = nb + 1;
  endtask

  // Drives the first nb bits of seq at ratio p. The start bit goes out one
  // half-cycle before posedge k; each bit is then held across its P posedges
  // ending at its bit end. Once the start is taken, the configuration inputs
  // are scrambled to show they are ignored mid-frame, and restored at the end.
  task automatic applyStimulus(input logic [15:0] seq, input int nb, input int p,
                               input logic pe, input logic pt);
    @(negedge clk);
    Prescale    = 6'(p);
    PAR_EN      = pe;
    PAR_TYP     = pt;
    RX_IN       = 1'b0;
    sampled_bit = 1'b0;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      if (i == 0) begin
        startCyc = cycle;
        Prescale = (p == 16) ? 6'd8 : 6'd16;
        PAR_EN   = ~pe;
        PAR_TYP  = ~pt;
      end
      RX_IN       = seq[i];
      sampled_bit = seq[i];
      repeat (p - 1) @(negedge clk);
    end
    Prescale = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
  endtask

  // Returns the line and the sampler output to idle-high.
  task automatic goIdle(input int cycles);
    @(negedge clk);
    RX_IN       = 1'b1;
    sampled_bit = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  // Directed sequence.
  initial begin
    logic [15:0] seq;
    int          nb;
    int          dvBase;
    int          brkBase;

    checks      = 0;
    fails       = 0;
    startCyc    = 0;
    rst         = 1'b1;
    RX_IN       = 1'b1;
    sampled_bit = 1'b1;
    Prescale    = 6'd8;
    PAR_EN      = 1'b0;
    PAR_TYP     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_dat_samp_en", 32'(dat_samp_en), 32'd0);
    checkOutput("rst_edge_cnt",    32'(edge_cnt),    32'd0);
    checkOutput("rst_P_DATA",      32'(P_DATA),      32'd0);
    checkOutput("rst_data_valid",  32'(data_valid),  32'd0);
    checkOutput("rst_par_err",     32'(par_err),     32'd0);
    checkOutput("rst_stop_err",    32'(stop_err),    32'd0);

    $display("[TB] P=8, no parity, 0xA5");
    dvBase = dvCount;
    makeFrame(8'hA5, 1'b0, 1'b0, 1'b1, seq, nb);
    applyStimulus(seq, nb, 8, 1'b0, 1'b0);
    goIdle(4);
    checkOutput("a5_dv_count",   32'(dvCount - dvBase), 32'd1);
    checkOutput("a5_latency",    32'(dvCyc[$] - startCyc), 32'd81);
    checkOutput("a5_dv_data",    32'(dvDat[$]), 32'hA5);
    checkOutput("a5_P_DATA",     32'(P_DATA),   32'hA5);
    checkOutput("a5_par_err",    32'(par_err),  32'd0);
    checkOutput("a5_stop_err",   32'(stop_err), 32'd0);
    checkOutput("a5_samp_en",    32'(dat_samp_en), 32'd0);

    $display("[TB] P=16, even parity, 0x3C, parity bit 0");
    dvBase = dvCount;
    makeFrame(8'h3C, 1'b1, 1'b0, 1'b1, seq, nb);
    applyStimulus(seq, nb, 16, 1'b1, 1'b0);
    goIdle(4);
    checkOutput("3c_dv_count",   32'(dvCount - dvBase), 32'd1);
    checkOutput("3c_latency",    32'(dvCyc[$] - startCyc), 32'd177);
    checkOutput("3c_P_DATA",     32'(P_DATA),   32'h3C);
    checkOutput("3c_par_err",    32'(par_err),  32'd0);

    $display("[TB] P=16, even parity, 0x3C, parity bit 1");
    dvBase = dvCount;
    makeFrame(8'h3C, 1'b1, 1'b1, 1'b1, seq, nb);
    applyStimulus(seq, nb, 16, 1'b1, 1'b0);
    goIdle(4);
    checkOutput("3cbad_dv_count", 32'(dvCount - dvBase), 32'd0);
    checkOutput("3cbad_par_err",  32'(par_err),  32'd1);
    checkOutput("3cbad_stop_err", 32'(stop_err), 32'd0);
    checkOutput("3cbad_P_DATA",   32'(P_DATA),   32'h3C);

    $display("[TB] P=8, 3-cycle glitch on the line");
    dvBase = dvCount;
    @(negedge clk);
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (3) @(negedge clk);
    RX_IN = 1'b1;
    checkOutput("glitch_samp_en_mid",  32'(dat_samp_en), 32'd1);
    checkOutput("glitch_edge_cnt_mid", 32'(edge_cnt),    32'd2);
    checkOutput("glitch_par_cleared",  32'(par_err),     32'd0);
    repeat (8) @(negedge clk);
    checkOutput("glitch_samp_en_end",  32'(dat_samp_en), 32'd0);
    checkOutput("glitch_edge_cnt_end", 32'(edge_cnt),    32'd0);
    checkOutput("glitch_stop_err",     32'(stop_err),    32'd0);
    checkOutput("glitch_dv_count",     32'(dvCount - dvBase), 32'd0);

    $display("[TB] P=32, 0x00 with stop bit low");
    dvBase  = dvCount;
    brkBase = brkCount;
    makeFrame(8'h00, 1'b0, 1'b0, 1'b0, seq, nb);
    applyStimulus(seq, nb, 32, 1'b0, 1'b0);
    goIdle(4);
    checkOutput("brk_dv_count", 32'(dvCount - dvBase), 32'd0);
    checkOutput("brk_stop_err", 32'(stop_err), 32'd1);
    checkOutput("brk_P_DATA",   32'(P_DATA),   32'h3C);
`ifdef UART_RX_BREAK_DET_EN
    checkOutput("brk_det_count", 32'(brkCount - brkBase), 32'd1);
`else
    checkOutput("brk_no_pulse",  32'(brkCount - brkBase), 32'd0);
`endif

    $display("[TB] reset during data bit 4, then 0x5A");
    dvBase = dvCount;
    makeFrame(8'hFF, 1'b0, 1'b0, 1'b1, seq, nb);
    applyStimulus(seq, 5, 8, 1'b0, 1'b0);
    @(negedge clk);
    RX_IN       = 1'b1;
    sampled_bit = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mid_samp_en", 32'(dat_samp_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_samp_en",  32'(dat_samp_en), 32'd0);
    checkOutput("midrst_edge_cnt", 32'(edge_cnt),    32'd0);
    checkOutput("midrst_P_DATA",   32'(P_DATA),      32'd0);
    checkOutput("midrst_dv",       32'(data_valid),  32'd0);
    checkOutput("midrst_par_err",  32'(par_err),     32'd0);
    checkOutput("midrst_stop_err", 32'(stop_err),    32'd0);
    goIdle(100);
    checkOutput("midrst_no_strobe", 32'(dvCount - dvBase), 32'd0);
    makeFrame(8'h5A, 1'b0, 1'b0, 1'b1, seq, nb);
    applyStimulus(seq, nb, 8, 1'b0, 1'b0);
    goIdle(4);
    checkOutput("5a_dv_count", 32'(dvCount - dvBase), 32'd1);
    checkOutput("5a_latency",  32'(dvCyc[$] - startCyc), 32'd81);
    checkOutput("5a_P_DATA",   32'(P_DATA), 32'h5A);

    $display("[TB] back-to-back 0x11, 0x22 at P=8");
    dvBase = dvCount;
    makeFrame(8'h11, 1'b0, 1'b0, 1'b1, seq, nb);
    applyStimulus(seq, nb, 8, 1'b0, 1'b0);
    makeFrame(8'h22, 1'b0, 1'b0, 1'b1, seq, nb);
    applyStimulus(seq, nb, 8, 1'b0, 1'b0);
    goIdle(4);
    checkOutput("b2b_dv_count", 32'(dvCount - dvBase), 32'd2);
    if (dvCount - dvBase == 2) begin
      checkOutput("b2b_first",   32'(dvDat[dvDat.size()-2]), 32'h11);
      checkOutput("b2b_second",  32'(dvDat[dvDat.size()-1]), 32'h22);
      checkOutput("b2b_spacing", 32'(dvCyc[dvCyc.size()-1] - dvCyc[dvCyc.size()-2]), 32'd81);
    end
    checkOutput("b2b_latency2", 32'(dvCyc[$] - startCyc), 32'd81);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
